dirty_sync_engine: RTL and testbench
====================================

DIRTY_SYNC_ENGINE -- requirements
Module: dirty_sync_engine

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width of the DM and IM ports.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter DEPTH, default 256: dirty-address FIFO entries; SHALL be a power of two, >=4.
REQ-004 Parameter RD_LAT, default 1: DM read latency in cycles, legal range 1..3.
REQ-005 i_clk  in  1  sole clock; all state on rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_wr_valid  in  1  DM write occurring this cycle.
REQ-008 i_wr_addr  in  ADDR_W  address of that DM write.
REQ-009 o_wr_ready  out  1  engine can record a write this cycle.
REQ-010 i_fence_i  in  1  single-cycle sync request.
REQ-011 o_dm_rd_en / o_dm_rd_addr  out  1 / ADDR_W  DM read request for drain.
REQ-012 i_dm_rd_data  in  DATA_W  DM read data, valid RD_LAT cycles after o_dm_rd_en.
REQ-013 o_im_wr_en / o_im_wr_addr / o_im_wr_data  out  1 / ADDR_W / DATA_W  IM write port.
REQ-014 o_ready  out  1  core may issue fetches and DM writes.
REQ-015 o_done  out  1  one-cycle pulse when a sync completes.
REQ-016 o_count  out  clog2(DEPTH)+1  dirty entries held.

Function
REQ-017 Write recorded when i_wr_valid && o_wr_ready; o_wr_ready = (state==IDLE) && (o_count<DEPTH).
REQ-018 Dedup: a write whose address equals the last recorded address (last-valid flag set) SHALL NOT be pushed; last-valid clears when FIFO empties.
REQ-019 States IDLE, DRAIN, FLUSH; IDLE->DRAIN when (i_fence_i or o_count==DEPTH) and FIFO non-empty after this cycle's push.
REQ-020 A write and i_fence_i in the same IDLE cycle: the write SHALL be recorded and included in the drain.
REQ-021 i_fence_i in IDLE with empty FIFO and no write: stay IDLE, o_done pulses next cycle.
REQ-022 DRAIN: one FIFO pop per cycle, o_dm_rd_en=1 with popped address; after last pop ->FLUSH.
REQ-023 Popped addresses SHALL be delayed RD_LAT cycles; o_im_wr_en=1 with delayed address and i_dm_rd_data.
REQ-024 FLUSH: remain until the delay pipeline is empty, then ->IDLE with o_done=1 in the IDLE-entry cycle.
REQ-025 Timing: fence at cycle t with N entries -> DM reads t+1..t+N, IM writes t+1+RD_LAT..t+N+RD_LAT, o_done at t+N+RD_LAT+1.
REQ-026 Full FIFO SHALL auto-start drain the next cycle without a fence; writes while full are back-pressured, never dropped silently.
REQ-027 i_fence_i in DRAIN or FLUSH SHALL be ignored.
REQ-028 o_ready = (state==IDLE) && (o_count<DEPTH).
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; o_count distinguishes full from empty.

Reset
REQ-030 i_rst_n low SHALL immediately force state IDLE, pointers/o_count 0, last-valid 0, delay pipeline empty.
REQ-031 During reset: o_wr_ready=0, o_ready=0, o_dm_rd_en=0, o_im_wr_en=0, o_done=0; address/data outputs 0.
REQ-032 Reset mid-drain SHALL abandon remaining entries with no further IM writes; deassertion is synchronised externally.

Structure
REQ-033 Package sync_pkg SHALL hold the state enum and RD_LAT legal-range constants.
REQ-034 Address FIFO SHALL be sub-module addr_fifo (push/pop/count, parametrised ADDR_W, DEPTH); engine holds FSM, dedup, delay line.

Verification
REQ-035 Writes 0x010,0x011,0x012 then fence, RD_LAT=1 -> IM writes of those addresses in order on cycles t+2..t+4, o_done at t+5.
REQ-036 Writes 0x020,0x020,0x020,0x021 then fence -> o_count=2, exactly two IM writes (0x020,0x021).
REQ-037 DEPTH=4, five back-to-back writes -> fifth held off (o_wr_ready=0), auto-drain of 4 entries, fifth accepted after o_done.
REQ-038 Write 0x030 and fence same cycle on empty FIFO -> one IM write to 0x030; fence alone on empty -> o_done next cycle, no IM write.
REQ-039 RD_LAT=3, 8 entries, i_rst_n low at 3rd DM read -> all outputs 0 immediately, no IM writes afterwards, o_count=0.
REQ-040 Fence pulsed again during DRAIN -> single o_done, no duplicate IM writes.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared types and constants for the dirty-line sync engine: FSM states,
// legal DM read-latency range and width helpers.
package sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Out-of-range latencies are pinned to the nearest legal value.
  function automatic int clamp_rd_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

  // Occupancy counter width: one extra bit so full and empty differ.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/addr_fifo.sv
// Circular FIFO of dirty DM word addresses. Pointers wrap modulo DEPTH
// (a power of two); the occupancy counter tells full from empty.
module addr_fifo
  import sync_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic [ADDR_W-1:0]         i_push_addr,
  input  logic                      i_pop,
  output logic [ADDR_W-1:0]         o_pop_addr,
  output logic [cnt_w(DEPTH)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = i_push && (count != FULL_CNT);
  assign pop_ok  = i_pop && (count != '0);

  // NOTE: storage is deliberately not reset; pointers and count alone define
  // which entries are live, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_push_addr;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign o_pop_addr = mem[rd_ptr];
  assign o_count    = count;

endmodule

// File: rtl/dirty_sync_engine.sv
// Records DM write addresses, and on fence.i (or a full FIFO) copies each
// dirty DM word into IM, honouring the DM read latency.
module dirty_sync_engine
  import sync_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_valid,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  output logic                     o_wr_ready,
  input  logic                     i_fence_i,
  output logic                     o_dm_rd_en,
  output logic [ADDR_W-1:0]        o_dm_rd_addr,
  input  logic [DATA_W-1:0]        i_dm_rd_data,
  output logic                     o_im_wr_en,
  output logic [ADDR_W-1:0]        o_im_wr_addr,
  output logic [DATA_W-1:0]        o_im_wr_data,
  output logic                     o_ready,
  output logic                     o_done,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int LAT   = clamp_rd_lat(RD_LAT);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] head_addr;
  logic              last_valid;
  logic [ADDR_W-1:0] last_addr;
  logic              idle_room;
  logic              accept;
  logic              push;
  logic              pop;
  logic              done_nxt;
  logic              done_q;
  logic [LAT-1:0]    pipe_v;
  logic [LAT-1:0]    pipe_v_nxt;
  logic [ADDR_W-1:0] pipe_a [LAT];

  // Ready outputs are gated by reset so they read 0 while it is held.
  assign idle_room  = (state == ST_IDLE) && (count < FULL_CNT);
  assign o_wr_ready = i_rst_n && idle_room;
  assign o_ready    = i_rst_n && idle_room;

  assign accept = i_wr_valid && o_wr_ready;
  assign push   = accept && !(last_valid && (i_wr_addr == last_addr));
  assign pop    = (state == ST_DRAIN);

  addr_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_push_addr (i_wr_addr),
    .i_pop       (pop),
    .o_pop_addr  (head_addr),
    .o_count     (count)
  );

  // NOTE: combinational blocks assign every output a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    pipe_v_nxt    = '0;
    pipe_v_nxt[0] = pop;
    for (int i = 1; i < LAT; i++) pipe_v_nxt[i] = pipe_v[i-1];
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_fence_i || (count == FULL_CNT)) begin
          if ((count != '0) || push) state_nxt = ST_DRAIN;
          else                       done_nxt  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (count == ONE_CNT) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Leave once the final in-flight read has reached IM this cycle.
        if (pipe_v_nxt == '0) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      done_q     <= 1'b0;
      last_valid <= 1'b0;
      last_addr  <= '0;
      pipe_v     <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      pipe_v <= pipe_v_nxt;
      if (push) begin
        last_valid <= 1'b1;
        last_addr  <= i_wr_addr;
      end else if (pop && (count == ONE_CNT)) begin
        last_valid <= 1'b0;
      end
    end
  end

  // Address delay line; qualified entirely by pipe_v.
  always_ff @(posedge i_clk) begin
    pipe_a[0] <= head_addr;
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end

  assign o_dm_rd_en   = pop;
  assign o_dm_rd_addr = pop ? head_addr : '0;
  assign o_im_wr_en   = pipe_v[LAT-1];
  assign o_im_wr_addr = o_im_wr_en ? pipe_a[LAT-1] : '0;
  assign o_im_wr_data = o_im_wr_en ? i_dm_rd_data : '0;
  assign o_done       = done_q;
  assign o_count      = count;

endmodule

// File: tb/tb_dirty_sync_engine.sv
// Bench for dirty_sync_engine: instance A (DEPTH=4, RD_LAT=1) covers the
// main sync flow, instance B (DEPTH=8, RD_LAT=3) covers reset mid-drain.
module tb_dirty_sync_engine;

  localparam int AW = 14;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Instance A
  logic          a_wr_valid = 1'b0;
  logic [AW-1:0] a_wr_addr  = '0;
  logic          a_fence    = 1'b0;
  logic          a_wr_ready, a_dm_rd_en, a_im_wr_en, a_ready, a_done;
  logic [AW-1:0] a_dm_rd_addr, a_im_wr_addr;
  logic [DW-1:0] a_dm_rd_data, a_im_wr_data;
  logic [2:0]    a_count;

  // Instance B
  logic          b_wr_valid = 1'b0;
  logic [AW-1:0] b_wr_addr  = '0;
  logic          b_fence    = 1'b0;
  logic          b_wr_ready, b_dm_rd_en, b_im_wr_en, b_ready, b_done;
  logic [AW-1:0] b_dm_rd_addr, b_im_wr_addr;
  logic [DW-1:0] b_dm_rd_data, b_im_wr_data;
  logic [3:0]    b_count;

  dirty_sync_engine #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4), .RD_LAT(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(a_wr_valid), .i_wr_addr(a_wr_addr), .o_wr_ready(a_wr_ready),
    .i_fence_i(a_fence),
    .o_dm_rd_en(a_dm_rd_en), .o_dm_rd_addr(a_dm_rd_addr), .i_dm_rd_data(a_dm_rd_data),
    .o_im_wr_en(a_im_wr_en), .o_im_wr_addr(a_im_wr_addr), .o_im_wr_data(a_im_wr_data),
    .o_ready(a_ready), .o_done(a_done), .o_count(a_count)
  );

  dirty_sync_engine #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(8), .RD_LAT(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(b_wr_valid), .i_wr_addr(b_wr_addr), .o_wr_ready(b_wr_ready),
    .i_fence_i(b_fence),
    .o_dm_rd_en(b_dm_rd_en), .o_dm_rd_addr(b_dm_rd_addr), .i_dm_rd_data(b_dm_rd_data),
    .o_im_wr_en(b_im_wr_en), .o_im_wr_addr(b_im_wr_addr), .o_im_wr_data(b_im_wr_data),
    .o_ready(b_ready), .o_done(b_done), .o_count(b_count)
  );

  // DM contents are a fixed function of the address.
  function automatic logic [DW-1:0] dm_fn(input logic [AW-1:0] a);
    return {4'hA, a, ~a};
  endfunction

  logic          a_rv = 1'b0;
  logic [AW-1:0] a_ra = '0;
  always @(posedge clk) begin
    a_rv <= a_dm_rd_en;
    a_ra <= a_dm_rd_addr;
  end
  assign a_dm_rd_data = a_rv ? dm_fn(a_ra) : 32'hDEAD_BEEF;

  logic [2:0]    b_rv = '0;
  logic [AW-1:0] b_ra [3];
  always @(posedge clk) begin
    b_rv    <= {b_rv[1:0], b_dm_rd_en};
    b_ra[0] <= b_dm_rd_addr;
    b_ra[1] <= b_ra[0];
    b_ra[2] <= b_ra[1];
  end
  assign b_dm_rd_data = b_rv[2] ? dm_fn(b_ra[2]) : 32'hDEAD_BEEF;

  // Scoreboard and observation queues for instance A
  logic [AW-1:0] exp_q [$];
  int            im_cyc_q [$];
  int            rd_cyc_q [$];
  int            done_cyc_q [$];
  logic          m_last_v = 1'b0;
  logic [AW-1:0] m_last   = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_dm_rd_en) rd_cyc_q.push_back(cyc);
      if (a_done)     done_cyc_q.push_back(cyc);
      if (a_im_wr_en) begin
        im_cyc_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL im_unexpected: got addr=%h data=%h at cycle %0d, none expected",
                   a_im_wr_addr, a_im_wr_data, cyc);
        end else begin
          logic [AW-1:0] e;
          e = exp_q.pop_front();
          if (a_im_wr_addr !== e || a_im_wr_data !== dm_fn(e)) begin
            errors++;
            $display("FAIL im_write: got addr=%h data=%h, expected addr=%h data=%h",
                     a_im_wr_addr, a_im_wr_data, e, dm_fn(e));
          end
        end
      end
    end
  end

  int b_im_n = 0;
  int b_rd_n = 0;
  always @(negedge clk) begin
    if (b_im_wr_en) b_im_n++;
    if (b_dm_rd_en) b_rd_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [AW-1:0] addr);
    if (!(m_last_v && addr == m_last)) exp_q.push_back(addr);
    m_last_v = 1'b1;
    m_last   = addr;
  endtask

  task automatic clear_obs();
    im_cyc_q.delete();
    rd_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic a_write(input logic [AW-1:0] addr, input logic fence);
    int n = 0;
    a_wr_valid = 1'b1;
    a_wr_addr  = addr;
    a_fence    = fence;
    while (!a_wr_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: addr=%h never accepted, expected acceptance", addr);
    end else begin
      model_write(addr);
    end
    tick();
    a_wr_valid = 1'b0;
    a_fence    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cyc_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (done_cyc_q.size() == 0) begin
      errors++;
      $display("FAIL %s_done_timeout: got no o_done, expected one", name);
    end
    m_last_v = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({a_wr_ready, a_ready, a_dm_rd_en, a_im_wr_en, a_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 00000",
               {a_wr_ready, a_ready, a_dm_rd_en, a_im_wr_en, a_done});
    end
    checks++;
    if (a_dm_rd_addr !== '0 || a_im_wr_addr !== '0 || a_im_wr_data !== '0 || a_count !== '0) begin
      errors++;
      $display("FAIL reset_data: got rd=%h im=%h data=%h cnt=%0d, expected zeros",
               a_dm_rd_addr, a_im_wr_addr, a_im_wr_data, a_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (a_wr_ready !== 1'b1 || a_ready !== 1'b1 || b_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got a_wr=%b a_rdy=%b b_wr=%b, expected 1 1 1",
               a_wr_ready, a_ready, b_wr_ready);
    end
  endtask

  task automatic test_basic();
    int t;
    clear_obs();
    a_write(14'h010, 1'b0);
    a_write(14'h011, 1'b0);
    a_write(14'h012, 1'b0);
    checks++;
    if (a_count !== 3'd3) begin
      errors++;
      $display("FAIL basic_count: got %0d, expected 3", a_count);
    end
    a_fence = 1'b1;
    t = cyc;
    tick();
    a_fence = 1'b0;
    wait_done("basic");
    checks++;
    if (rd_cyc_q.size() != 3 || im_cyc_q.size() != 3) begin
      errors++;
      $display("FAIL basic_n: got rd=%0d im=%0d, expected 3 3", rd_cyc_q.size(), im_cyc_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_cyc_q[k] != t + 1 + k || im_cyc_q[k] != t + 2 + k) begin
          errors++;
          $display("FAIL basic_timing[%0d]: got rd@%0d im@%0d, expected rd@%0d im@%0d",
                   k, rd_cyc_q[k], im_cyc_q[k], t + 1 + k, t + 2 + k);
        end
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != t + 5) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses first@%0d, expected 1 @%0d",
               done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, t + 5);
    end
  endtask

  task automatic test_dedup();
    clear_obs();
    a_write(14'h020, 1'b0);
    a_write(14'h020, 1'b0);
    a_write(14'h020, 1'b0);
    a_write(14'h021, 1'b0);
    checks++;
    if (a_count !== 3'd2) begin
      errors++;
      $display("FAIL dedup_count: got %0d, expected 2", a_count);
    end
    a_fence = 1'b1;
    tick();
    a_fence = 1'b0;
    wait_done("dedup");
    checks++;
    if (im_cyc_q.size() != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL dedup_writes: got %0d IM writes (%0d pending), expected 2 (0)",
               im_cyc_q.size(), exp_q.size());
    end
  endtask

  task automatic test_same_cycle();
    int t;
    clear_obs();
    t = cyc;
    a_write(14'h030, 1'b1);
    wait_done("same");
    checks++;
    if (im_cyc_q.size() != 1 || done_cyc_q[0] != t + 3) begin
      errors++;
      $display("FAIL same_cycle: got %0d IM writes done@%0d, expected 1 done@%0d",
               im_cyc_q.size(), done_cyc_q[0], t + 3);
    end
    tick();
    clear_obs();
    a_fence = 1'b1;
    t = cyc;
    tick();
    a_fence = 1'b0;
    repeat (4) tick();
    checks++;
    if (done_cyc_q.size() != 1 || im_cyc_q.size() != 0 || rd_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL empty_fence: got done=%0d im=%0d rd=%0d, expected 1 0 0",
               done_cyc_q.size(), im_cyc_q.size(), rd_cyc_q.size());
    end else begin
      checks++;
      if (done_cyc_q[0] != t + 1) begin
        errors++;
        $display("FAIL empty_fence_time: got done@%0d, expected @%0d", done_cyc_q[0], t + 1);
      end
    end
  endtask

  task automatic test_full();
    int w4;
    int n = 0;
    clear_obs();
    a_write(14'h040, 1'b0);
    a_write(14'h041, 1'b0);
    a_write(14'h042, 1'b0);
    w4 = cyc;
    a_write(14'h043, 1'b0);
    checks++;
    if (a_wr_ready !== 1'b0 || a_ready !== 1'b0 || a_count !== 3'd4) begin
      errors++;
      $display("FAIL full_backpressure: got wr_ready=%b ready=%b cnt=%0d, expected 0 0 4",
               a_wr_ready, a_ready, a_count);
    end
    a_wr_valid = 1'b1;
    a_wr_addr  = 14'h044;
    while (!a_wr_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL full_fifth_timeout: got wr_ready=0, expected 1 after drain");
    end else if (a_done !== 1'b1 || im_cyc_q.size() != 4 || rd_cyc_q.size() != 4) begin
      errors++;
      $display("FAIL full_autodrain: got done=%b im=%0d rd=%0d, expected 1 4 4",
               a_done, im_cyc_q.size(), rd_cyc_q.size());
    end else begin
      checks++;
      if (rd_cyc_q[0] != w4 + 2) begin
        errors++;
        $display("FAIL full_autostart: got first read@%0d, expected @%0d", rd_cyc_q[0], w4 + 2);
      end
    end
    m_last_v = 1'b0;
    model_write(14'h044);
    tick();
    a_wr_valid = 1'b0;
    done_cyc_q.delete();
    a_fence = 1'b1;
    tick();
    a_fence = 1'b0;
    wait_done("full");
    checks++;
    if (im_cyc_q.size() != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_total: got %0d IM writes (%0d pending), expected 5 (0)",
               im_cyc_q.size(), exp_q.size());
    end
  endtask

  task automatic test_fence_during_drain();
    int t;
    clear_obs();
    a_write(14'h050, 1'b0);
    a_write(14'h051, 1'b0);
    a_write(14'h052, 1'b0);
    a_fence = 1'b1;
    t = cyc;
    tick();
    a_fence = 1'b0;
    tick();
    a_fence = 1'b1;
    tick();
    a_fence = 1'b0;
    tick();
    a_fence = 1'b1;
    tick();
    a_fence = 1'b0;
    repeat (6) tick();
    m_last_v = 1'b0;
    checks++;
    if (done_cyc_q.size() != 1 || im_cyc_q.size() != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL refence: got done=%0d im=%0d pending=%0d, expected 1 3 0",
               done_cyc_q.size(), im_cyc_q.size(), exp_q.size());
    end else begin
      checks++;
      if (done_cyc_q[0] != t + 5) begin
        errors++;
        $display("FAIL refence_time: got done@%0d, expected @%0d", done_cyc_q[0], t + 5);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      b_wr_valid = 1'b1;
      b_wr_addr  = AW'(14'h060 + i);
      tick();
    end
    b_wr_valid = 1'b0;
    checks++;
    if (b_count !== 4'd8) begin
      errors++;
      $display("FAIL b_fill: got count=%0d, expected 8", b_count);
    end
    while (b_dm_rd_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    checks++;
    if (b_dm_rd_en !== 1'b1 || b_rd_n != 2) begin
      errors++;
      $display("FAIL b_third_read: got rd_en=%b reads=%0d, expected 1 2", b_dm_rd_en, b_rd_n);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b_wr_ready, b_ready, b_dm_rd_en, b_im_wr_en, b_done} !== 5'b0 || b_count !== '0) begin
      errors++;
      $display("FAIL b_reset_ctrl: got %b cnt=%0d, expected 00000 cnt=0",
               {b_wr_ready, b_ready, b_dm_rd_en, b_im_wr_en, b_done}, b_count);
    end
    checks++;
    if (b_dm_rd_addr !== '0 || b_im_wr_addr !== '0 || b_im_wr_data !== '0) begin
      errors++;
      $display("FAIL b_reset_data: got rd=%h im=%h data=%h, expected zeros",
               b_dm_rd_addr, b_im_wr_addr, b_im_wr_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    checks++;
    if (b_im_n != 0 || b_count !== '0 || b_rd_n != 2) begin
      errors++;
      $display("FAIL b_abandon: got im=%0d cnt=%0d reads=%0d, expected 0 0 2",
               b_im_n, b_count, b_rd_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dedup();
    test_same_cycle();
    test_full();
    test_fence_during_drain();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
